program_sequencer: RTL and testbench

Run controller for the 10-bit CPU. It owns a small instruction memory and loads it from an external valid/ready stream. It then holds the CPU in reset, releases it, and serves `instruction` combinationally from the CPU's fetch address. It gates CPU progress with a clock enable (free-run or single-step) and stops on `donebit`, an out-of-range fetch, or a cycle timeout, reporting cycle count and error code.

---
 rtl/program_sequencer.sv | 170 +++++++++++++++++
 tb/tb_program_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Run controller for the 10-bit CPU: loads a program from a valid/ready stream,
// sequences CPU reset/clock-enable, and reports cycle count and stop reason.
module program_sequencer #(
  parameter int          DEPTH      = 64,
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_valid,
  input  logic [9:0]                load_data,
  input  logic                      load_last,
  output logic                      load_ready,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      step_mode,
  input  logic                      step,
  input  logic [9:0]                instr_rd_addr,
  input  logic                      donebit,
  output logic [9:0]                instruction,
  output logic                      cpu_reset_n,
  output logic                      cpu_clk_en,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                err,
  output logic [$clog2(DEPTH):0]    program_len,
  output logic [15:0]               cycle_count
);

  // state  | meaning
  // IDLE   | CPU held in reset, waiting for a load beat or start
  // LOAD   | receiving program words into mem[wptr]
  // ARM    | one cycle, clears cycle_count/err before release
  // RUN    | CPU out of reset, clock enable gated by step logic
  // HALT   | CPU stopped but not reset, state inspectable

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEN_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] LEN_FULL = {1'b1, {AW{1'b0}}};

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_RUN, S_HALT} state_t;

  state_t        state, state_next;
  logic [9:0]    mem [DEPTH];
  logic [AW:0]   wptr, wptr_next, len_next;
  logic [15:0]   cnt_next;
  logic [1:0]    err_next;
  logic          step_q;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          in_range, step_edge, full;

  assign in_range    = {1'b0, instr_rd_addr} < 11'(program_len);
  assign step_edge   = step && !step_q;
  assign full        = wptr[AW];  // wptr never exceeds DEPTH, so the top bit means full
  assign instruction = in_range ? mem[instr_rd_addr[AW-1:0]] : 10'h000;

  always_comb begin
    state_next  = state;
    wptr_next   = wptr;
    len_next    = program_len;
    cnt_next    = cycle_count;
    err_next    = err;
    mem_we      = 1'b0;
    mem_waddr   = wptr[AW-1:0];
    load_ready  = 1'b0;
    cpu_reset_n = 1'b0;
    cpu_clk_en  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_IDLE, S_HALT: begin
        load_ready  = !abort;
        cpu_reset_n = (state == S_HALT);
        done        = (state == S_HALT);
        if (abort) begin
          state_next = S_IDLE;
        end else if (load_valid) begin
          mem_we     = 1'b1;
          mem_waddr  = '0;
          wptr_next  = LEN_ONE;
          err_next   = ERR_NONE;
          if (load_last) begin
            len_next   = LEN_ONE;
            state_next = S_IDLE;
          end else begin
            state_next = S_LOAD;
          end
        end else if (start && program_len != '0) begin
          state_next = S_ARM;
        end
      end
      S_LOAD: begin
        load_ready = !full && !abort;
        if (abort) begin
          state_next = S_IDLE;
        end else if (load_valid) begin
          if (full) begin
            err_next   = ERR_OVERFLOW;
            len_next   = LEN_FULL;
            state_next = S_IDLE;
          end else begin
            mem_we    = 1'b1;
            wptr_next = wptr + LEN_ONE;
            if (load_last) begin
              len_next   = wptr + LEN_ONE;
              state_next = S_IDLE;
            end
          end
        end
      end
      S_ARM: begin
        busy = 1'b1;
        if (abort) begin
          state_next = S_IDLE;
        end else begin
          cnt_next   = '0;
          err_next   = ERR_NONE;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy        = 1'b1;
        cpu_reset_n = 1'b1;
        cpu_clk_en  = in_range && (!step_mode || step_edge);
        if (cpu_clk_en && cycle_count != 16'hFFFF) cnt_next = cycle_count + 16'd1;
        if (abort) begin
          state_next = S_IDLE;
        end else if (!in_range) begin
          err_next   = ERR_RANGE;
          state_next = S_HALT;
        end else if (cpu_clk_en && donebit) begin
          state_next = S_HALT;
        end else if (cpu_clk_en && (cycle_count + 16'd1) == MAX_CYCLES) begin
          err_next   = ERR_TIMEOUT;
          state_next = S_HALT;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      wptr        <= '0;
      program_len <= '0;
      cycle_count <= '0;
      err         <= ERR_NONE;
      step_q      <= 1'b0;
    end else begin
      state       <= state_next;
      wptr        <= wptr_next;
      program_len <= len_next;
      cycle_count <= cnt_next;
      err         <= err_next;
      step_q      <= step;
    end
  end

  // Memory has no reset; program_len=0 keeps stale words unreachable.
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[mem_waddr] <= load_data;
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: vector table for a load-and-run pass,
// then hand sequences for range halt, single-step, timeout, reset and overflow.
module tb_program_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [9:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic        start;
  logic        abort;
  logic        step_mode;
  logic        step;
  logic [9:0]  instr_rd_addr;
  logic        donebit;
  logic [9:0]  instruction;
  logic        cpu_reset_n;
  logic        cpu_clk_en;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [2:0]  program_len;
  logic [15:0] cycle_count;

  int errors = 0;
  int checks = 0;

  program_sequencer #(.DEPTH(4), .MAX_CYCLES(16'd5)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .start(start), .abort(abort),
    .step_mode(step_mode), .step(step), .instr_rd_addr(instr_rd_addr),
    .donebit(donebit), .instruction(instruction), .cpu_reset_n(cpu_reset_n),
    .cpu_clk_en(cpu_clk_en), .busy(busy), .done(done), .err(err),
    .program_len(program_len), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lv;
    logic [9:0] ld;
    logic       ll;
    logic       st;
    logic [9:0] addr;
    logic       db;
    logic       e_ready;
    logic [9:0] e_instr;
    logic       e_rstn;
    logic       e_en;
    logic       e_busy;
    logic       e_done;
    logic [1:0] e_err;
    logic [2:0] e_len;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt [9];
  logic step_pat [20];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ens;
    logic prev;
    logic seen;

    //        lv ld      ll st addr  db | rdy instr   rstn en busy done err len cnt
    vt[0] = '{1, 10'h101, 0, 0, 10'd0, 0,  1, 10'h000, 0, 0, 0, 0, 2'd0, 3'd0, 16'd0};
    vt[1] = '{1, 10'h0B2, 0, 0, 10'd0, 0,  1, 10'h000, 0, 0, 0, 0, 2'd0, 3'd0, 16'd0};
    vt[2] = '{1, 10'h0C3, 1, 0, 10'd0, 0,  1, 10'h000, 0, 0, 0, 0, 2'd0, 3'd0, 16'd0};
    vt[3] = '{0, 10'h000, 0, 1, 10'd0, 0,  1, 10'h101, 0, 0, 0, 0, 2'd0, 3'd3, 16'd0};
    vt[4] = '{0, 10'h000, 0, 0, 10'd0, 0,  0, 10'h101, 0, 0, 1, 0, 2'd0, 3'd3, 16'd0};
    vt[5] = '{0, 10'h000, 0, 0, 10'd0, 0,  0, 10'h101, 1, 1, 1, 0, 2'd0, 3'd3, 16'd0};
    vt[6] = '{0, 10'h000, 0, 0, 10'd1, 0,  0, 10'h0B2, 1, 1, 1, 0, 2'd0, 3'd3, 16'd1};
    vt[7] = '{0, 10'h000, 0, 0, 10'd2, 1,  0, 10'h0C3, 1, 1, 1, 0, 2'd0, 3'd3, 16'd2};
    vt[8] = '{0, 10'h000, 0, 0, 10'd2, 0,  1, 10'h0C3, 1, 0, 0, 1, 2'd0, 3'd3, 16'd3};

    for (int i = 0; i < 20; i++) step_pat[i] = (i == 10) || (i >= 13 && i <= 17);

    reset = 1'b0; load_valid = 0; load_data = '0; load_last = 0; start = 0;
    abort = 0; step_mode = 0; step = 0; instr_rd_addr = '0; donebit = 0;
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    chk("rst load_ready", 16'(load_ready), 16'd1);
    chk("rst cpu_reset_n", 16'(cpu_reset_n), 16'd0);
    chk("rst cpu_clk_en", 16'(cpu_clk_en), 16'd0);
    chk("rst busy", 16'(busy), 16'd0);
    chk("rst done", 16'(done), 16'd0);
    chk("rst instruction", 16'(instruction), 16'd0);
    chk("rst err", 16'(err), 16'd0);
    chk("rst program_len", 16'(program_len), 16'd0);
    chk("rst cycle_count", cycle_count, 16'd0);

    // Load A,B,C and run to donebit on fetch 2
    for (int i = 0; i < 9; i++) begin
      load_valid = vt[i].lv; load_data = vt[i].ld; load_last = vt[i].ll;
      start = vt[i].st; instr_rd_addr = vt[i].addr; donebit = vt[i].db;
      #1;
      chk($sformatf("v%0d load_ready", i), 16'(load_ready), 16'(vt[i].e_ready));
      chk($sformatf("v%0d instruction", i), 16'(instruction), 16'(vt[i].e_instr));
      chk($sformatf("v%0d cpu_reset_n", i), 16'(cpu_reset_n), 16'(vt[i].e_rstn));
      chk($sformatf("v%0d cpu_clk_en", i), 16'(cpu_clk_en), 16'(vt[i].e_en));
      chk($sformatf("v%0d busy", i), 16'(busy), 16'(vt[i].e_busy));
      chk($sformatf("v%0d done", i), 16'(done), 16'(vt[i].e_done));
      chk($sformatf("v%0d err", i), 16'(err), 16'(vt[i].e_err));
      chk($sformatf("v%0d program_len", i), 16'(program_len), 16'(vt[i].e_len));
      chk($sformatf("v%0d cycle_count", i), cycle_count, vt[i].e_cnt);
      cyc();
    end

    // Two-word program from HALT, then fetch runs past the end
    load_valid = 1; load_data = 10'h2AA; load_last = 0; instr_rd_addr = '0;
    cyc();
    load_data = 10'h155; load_last = 1;
    cyc();
    load_valid = 0; load_last = 0; start = 1;
    #1;
    chk("oor program_len", 16'(program_len), 16'd2);
    cyc();
    start = 0;
    cyc();
    #1;
    chk("oor en addr0", 16'(cpu_clk_en), 16'd1);
    chk("oor instr addr0", 16'(instruction), 16'h2AA);
    cyc();
    instr_rd_addr = 10'd1;
    #1;
    chk("oor instr addr1", 16'(instruction), 16'h155);
    cyc();
    instr_rd_addr = 10'd2;
    #1;
    chk("oor en addr2", 16'(cpu_clk_en), 16'd0);
    chk("oor instr addr2", 16'(instruction), 16'd0);
    cyc();
    chk("oor done", 16'(done), 16'd1);
    chk("oor err", 16'(err), 16'd2);
    chk("oor cycle_count", cycle_count, 16'd2);

    // Single-step: idle step, one short pulse, one held pulse
    instr_rd_addr = '0; step_mode = 1; step = 0; start = 1;
    cyc();
    start = 0;
    cyc();
    chk("step in run", 16'(busy), 16'd1);
    ens = 0; prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step = step_pat[i];
      #1;
      chk($sformatf("step en c%0d", i), 16'(cpu_clk_en), 16'(step_pat[i] && !prev));
      ens += int'(cpu_clk_en);
      prev = step_pat[i];
      cyc();
    end
    chk("step en total", 16'(ens), 16'd2);
    chk("step cycle_count", cycle_count, 16'd2);

    abort = 1;
    cyc();
    abort = 0;
    #1;
    chk("abort busy", 16'(busy), 16'd0);
    chk("abort cpu_reset_n", 16'(cpu_reset_n), 16'd0);
    chk("abort program_len", 16'(program_len), 16'd2);

    // Timeout after MAX_CYCLES enabled cycles, then restart from HALT
    step_mode = 0; step = 0; start = 1;
    cyc();
    start = 0;
    cyc();
    ens = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (done) seen = 1'b1;
      else begin
        ens += int'(cpu_clk_en);
        cyc();
      end
    end
    chk("tmo reached halt", 16'(seen), 16'd1);
    chk("tmo en total", 16'(ens), 16'd5);
    chk("tmo err", 16'(err), 16'd3);
    chk("tmo cycle_count", cycle_count, 16'd5);

    start = 1;
    cyc();
    start = 0;
    chk("restart arm busy", 16'(busy), 16'd1);
    chk("restart arm cpu_reset_n", 16'(cpu_reset_n), 16'd0);
    cyc();
    chk("restart cycle_count", cycle_count, 16'd0);
    chk("restart err", 16'(err), 16'd0);
    chk("restart en", 16'(cpu_clk_en), 16'd1);
    cyc();
    cyc();
    cyc();
    chk("pre-reset cycle_count", cycle_count, 16'd3);

    // Reset during RUN discards the program
    reset = 0;
    cyc();
    reset = 1;
    #1;
    chk("midrst busy", 16'(busy), 16'd0);
    chk("midrst program_len", 16'(program_len), 16'd0);
    chk("midrst cpu_reset_n", 16'(cpu_reset_n), 16'd0);
    chk("midrst cycle_count", cycle_count, 16'd0);
    chk("midrst instruction", 16'(instruction), 16'd0);
    start = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("start ignored c%0d", i), 16'(busy), 16'd0);
    end
    start = 0;

    // Overflow: five beats into a four-word memory
    for (int i = 0; i < 5; i++) begin
      load_valid = 1; load_last = 0; load_data = 10'(10'h3A0 + i);
      #1;
      chk($sformatf("ovf ready beat%0d", i), 16'(load_ready), 16'(i < 4));
      cyc();
    end
    load_valid = 0;
    #1;
    chk("ovf err", 16'(err), 16'd1);
    chk("ovf program_len", 16'(program_len), 16'd4);
    chk("ovf idle ready", 16'(load_ready), 16'd1);
    chk("ovf busy", 16'(busy), 16'd0);
    instr_rd_addr = 10'd3;
    #1;
    chk("ovf instr addr3", 16'(instruction), 16'h3A3);
    instr_rd_addr = 10'd0;
    #1;
    chk("ovf instr addr0", 16'(instruction), 16'h3A0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
